// File: rtl/lsu_ctrl.sv
// Load/store unit: turns byte-addressed RISC-V loads/stores into word accesses,
// doing read-modify-write for sub-word stores and extending load results.
module lsu_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

  state_e              state_q, state_d;
  logic [2:0]          funct3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wr_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic                accept;
  logic                dec_err;
  logic [31:0]         lane_shift;
  logic [31:0]         load_ext;
  logic [31:0]         merged;
  logic                unused_addr;

  assign unused_addr = ^req_addr_i[31:ADDR_W+2];

  // Misaligned or unsupported encodings never reach memory.
  assign dec_err = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                   (req_we_i && req_funct3_i[2]) ||
                   ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_funct3_i == 3'b010) && (req_addr_i[1:0] != 2'b00));

  assign accept      = (state_q == StIdle) && req_valid_i;
  assign req_ready_o = (state_q == StIdle) && !reset_i;
  assign rsp_valid_o = (state_q == StResp);
  assign stall_o     = (state_q != StIdle);
  assign mem_read_o  = (state_q == StLoad) || (state_q == StRmwRd);
  assign mem_write_o = (state_q == StWrite) && !reset_i;
  assign mem_addr_o  = addr_q[ADDR_W+1:2];
  assign mem_wdata_o = wr_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    lane_shift = mem_rdata_i >> {addr_q[1:0], 3'b000};
    unique case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & lane_shift[7]}}, lane_shift[7:0]};
      2'b01:   load_ext = {{16{~funct3_q[2] & lane_shift[15]}}, lane_shift[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // wr_q still holds the store data while the old word is being read.
  always_comb begin
    merged = mem_rdata_i;
    if (funct3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wr_q[15:0];
    else             merged[{addr_q[1:0], 3'b000} +: 8] = wr_q[7:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (dec_err)                         state_d = StResp;
          else if (!req_we_i)                  state_d = StLoad;
          else if (req_funct3_i[1:0] == 2'b10) state_d = StWrite;
          else                                 state_d = StRmwRd;
        end
      end
      StLoad:  state_d = StResp;
      StRmwRd: state_d = StWrite;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wr_q     <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i[ADDR_W+1:0];
        wr_q     <= req_wdata_i;
        if (dec_err) begin
          rdata_q <= 32'h0;
          err_q   <= 1'b1;
        end
      end
      case (state_q)
        StLoad: begin
          rdata_q <= load_ext;
          err_q   <= 1'b0;
        end
        StRmwRd: wr_q <= merged;
        StWrite: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: constant vector table, corner sequences and random
// traffic checked against an arithmetic model of memory and responses.
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        stall_o;
  logic [9:0]  mem_addr_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int n_cmp  = 0;
  int n_fail = 0;

  lsu_ctrl #(.ADDR_W(10)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .stall_o      (stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = mem[mem_addr_o];
  always @(posedge clk_i) if (mem_write_o) mem[mem_addr_o] <= mem_wdata_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-lane arithmetic on ref_mem; updates ref_mem for stores.
  task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wdata, output bit [31:0] rd, output bit err,
                       output int lat, output int nrd, output int nwr);
    int w   = int'((addr >> 2) % 1024);
    int off = int'(addr % 4);
    int sz  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    longint unsigned word = longint'(ref_mem[w]);
    longint unsigned v;
    err = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5)) ||
          ((f3 == 1 || f3 == 5) && (off % 2 != 0)) || (f3 == 2 && off != 0);
    rd = 0; lat = 1; nrd = 0; nwr = 0;
    if (err) return;
    if (!we) begin
      lat = 2; nrd = 1;
      if (sz == 4) v = word;
      else begin
        v = (word >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if (f3 < 4 && v >= (64'd1 << (8 * sz - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * sz));
      end
      rd = v[31:0];
    end else begin
      nwr = 1;
      nrd = (sz == 4) ? 0 : 1;
      lat = (sz == 4) ? 2 : 3;
      for (int b = 0; b < 4; b++) begin
        if (b >= off && b < off + sz) begin
          word = (word & ~(64'hFF << (8 * b))) |
                 (((longint'(wdata) >> (8 * (b - off))) & 64'hFF) << (8 * b));
        end
      end
      ref_mem[w] = word[31:0];
    end
  endtask

  // Full transaction from an IDLE cycle (called #1 after a rising edge).
  task automatic run_txn(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wdata, output bit [31:0] rd, output bit err);
    bit [31:0] e_rd; bit e_err; int e_lat, e_nrd, e_nwr;
    int nrd = 0, nwr = 0, lat = 0;
    bit got = 0, stall_ok = 1;
    int w = int'((addr >> 2) % 1024);
    model(we, f3, addr, wdata, e_rd, e_err, e_lat, e_nrd, e_nwr);
    chk("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk_i); #1;
    req_valid_i = 0; req_we_i = ~we; req_addr_i = ~addr;
    rd = 32'hX; err = 1'bX;
    for (int k = 1; k <= 10 && !got; k++) begin
      if (mem_read_o)  nrd++;
      if (mem_write_o) nwr++;
      if (!stall_o || req_ready_o) stall_ok = 0;
      if (rsp_valid_o) begin
        got = 1; lat = k; rd = rsp_rdata_o; err = rsp_err_o;
      end else begin
        @(posedge clk_i); #1;
      end
    end
    if (!got) $display("FAIL rsp_timeout: got no response, expected one within 10 cycles");
    chk("rsp_seen", 32'(got), 32'd1);
    chk("latency", lat, e_lat);
    chk("rsp_rdata", rd, e_rd);
    chk("rsp_err", 32'(err), 32'(e_err));
    chk("mem_reads", nrd, e_nrd);
    chk("mem_writes", nwr, e_nwr);
    chk("stall_busy", 32'(stall_ok), 32'd1);
    @(posedge clk_i); #1;
    chk("rsp_one_pulse", 32'(rsp_valid_o), 32'd0);
    chk("rdata_hold", rsp_rdata_o, e_rd);
    chk("mem_word", mem[w], ref_mem[w]);
  endtask

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp_rd;
    bit        exp_err;
  } vec_t;

  initial begin
    vec_t      tbl[16];
    bit [31:0] rd;
    bit        err;
    int        nrsp, nacc;
    bit        overlap_ok;

    tbl[0]  = '{0, 3'b000, 32'h16, 32'h0, 32'hFFFF_FF81, 0};
    tbl[1]  = '{0, 3'b100, 32'h16, 32'h0, 32'h0000_0081, 0};
    tbl[2]  = '{0, 3'b101, 32'h16, 32'h0, 32'h0000_8081, 0};
    tbl[3]  = '{0, 3'b001, 32'h14, 32'h0, 32'hFFFF_82F3, 0};
    tbl[4]  = '{0, 3'b010, 32'h14, 32'h0, 32'h8081_82F3, 0};
    tbl[5]  = '{1, 3'b010, 32'h14, 32'h1122_3344, 32'h0, 0};
    tbl[6]  = '{1, 3'b000, 32'h15, 32'h0000_00AA, 32'h0, 0};
    tbl[7]  = '{0, 3'b010, 32'h14, 32'h0, 32'h1122_AA44, 0};
    tbl[8]  = '{1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 0};
    tbl[9]  = '{0, 3'b010, 32'h20, 32'h0, 32'hDEAD_BEEF, 0};
    tbl[10] = '{0, 3'b010, 32'h22, 32'h0, 32'h0, 1};
    tbl[11] = '{1, 3'b001, 32'h13, 32'h0000_5555, 32'h0, 1};
    tbl[12] = '{0, 3'b011, 32'h20, 32'h0, 32'h0, 1};
    tbl[13] = '{1, 3'b001, 32'h22, 32'h1234_5678, 32'h0, 0};
    tbl[14] = '{0, 3'b010, 32'h8000_1020, 32'h0, 32'h5678_BEEF, 0};
    tbl[15] = '{0, 3'b000, 32'h23, 32'h0, 32'h0000_0056, 0};

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[5] = 32'h8081_82F3;
    ref_mem[5] = 32'h8081_82F3;

    reset_i = 1; req_valid_i = 0; req_we_i = 0; req_funct3_i = 0;
    req_addr_i = 0; req_wdata_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ready", 32'(req_ready_o), 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'd0);
    chk("reset_err", 32'(rsp_err_o), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("reset_mem_wdata", mem_wdata_o, 32'd0);
    chk("reset_mem_rw", {30'd0, mem_read_o, mem_write_o}, 32'd0);
    reset_i = 0;
    #1;
    chk("ready_after_reset", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;

    for (int i = 0; i < 16; i++) begin
      run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, err);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
    end

    // Back-to-back loads with valid held high: accepts every third cycle.
    req_valid_i = 1; req_we_i = 0; req_funct3_i = 3'b010; req_addr_i = 32'h20;
    nrsp = 0; nacc = 0; overlap_ok = 1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready_o) nacc++;
      if (req_ready_o == stall_o) overlap_ok = 0;
      if (rsp_valid_o) begin
        nrsp++;
        chk("b2b_rdata", rsp_rdata_o, 32'h5678_BEEF);
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 0;
    chk("b2b_accepts", nacc, 4);
    chk("b2b_responses", nrsp, 4);
    chk("b2b_ready_vs_stall", 32'(overlap_ok), 32'd1);
    @(posedge clk_i); #1;
    chk("b2b_no_extra_rsp", 32'(rsp_valid_o), 32'd0);

    // Reset during the WRITE cycle of an SB aborts it cleanly.
    run_txn(1, 3'b010, 32'h24, 32'hCAFE_F00D, rd, err);
    req_valid_i = 1; req_we_i = 1; req_funct3_i = 3'b000; req_addr_i = 32'h26;
    req_wdata_i = 32'h0000_0011;
    @(posedge clk_i); #1;
    req_valid_i = 0;
    chk("abort_rmw_read", 32'(mem_read_o), 32'd1);
    @(posedge clk_i); #1;
    chk("abort_write_phase", 32'(mem_write_o), 32'd1);
    reset_i = 1;
    #1;
    chk("abort_write_gated", 32'(mem_write_o), 32'd0);
    @(posedge clk_i); #1;
    reset_i = 0;
    #1;
    chk("abort_mem_unchanged", mem[9], 32'hCAFE_F00D);
    chk("abort_idle", 32'(stall_o), 32'd0);
    chk("abort_ready", 32'(req_ready_o), 32'd1);
    nrsp = 0;
    repeat (4) begin
      if (rsp_valid_o) nrsp++;
      @(posedge clk_i); #1;
    end
    chk("abort_no_rsp", nrsp, 0);

    // Random traffic over 16 words with random upper address bits.
    for (int i = 0; i < 150; i++) begin
      bit [31:0] a = $urandom();
      a[11:6] = 6'd0;
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(), rd, err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
